// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_pkg
// Description : Shared fixed-point helpers for the pipelined arithmetic blocks
//               (pipe_fixed_point_mul, pipe_FixedPointDiv).
//               - fraction alignment with optional round-half-up
//               - signed output range limits for a given output width
//               - range test and clamp-or-pass-through selection
//               All helpers work on a wide signed container so any realistic
//               operand/result width fits without a per-width function.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

    localparam int c_FXP_ACC_W = 128;

    typedef logic signed [c_FXP_ACC_W-1:0] fxp_acc_t;

    localparam fxp_acc_t c_FXP_ONE = fxp_acc_t'(1);

    // Move a value with some fraction bits to a target fraction count.
    // s > 0 drops s fraction bits (optionally adding half an output LSB
    // first, i.e. round-half-up); s < 0 appends -s zero fraction bits.
    function automatic fxp_acc_t fxp_align(input fxp_acc_t v, input int s, input bit rnd);
        fxp_acc_t r;
        r = v;
        if (s > 0) begin
            if (rnd) begin
                r = r + (c_FXP_ONE <<< (s - 1));
            end
            r = r >>> s;
        end else if (s < 0) begin
            r = r <<< (-s);
        end
        return r;
    endfunction

    // Largest representable value of a w-bit signed result.
    function automatic fxp_acc_t fxp_out_max(input int w);
        return (c_FXP_ONE <<< (w - 1)) - c_FXP_ONE;
    endfunction

    // Smallest representable value of a w-bit signed result.
    function automatic fxp_acc_t fxp_out_min(input int w);
        return -(c_FXP_ONE <<< (w - 1));
    endfunction

    function automatic logic fxp_out_of_range(input fxp_acc_t v, input int w);
        return (v > fxp_out_max(w)) || (v < fxp_out_min(w));
    endfunction

    // With sat set, clamp to the w-bit range; otherwise return v unchanged so
    // the caller's truncation to w bits produces the wrapped result.
    function automatic fxp_acc_t fxp_saturate(input fxp_acc_t v, input int w, input bit sat);
        fxp_acc_t r;
        r = v;
        if (sat) begin
            if (v > fxp_out_max(w)) begin
                r = fxp_out_max(w);
            end else if (v < fxp_out_min(w)) begin
                r = fxp_out_min(w);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_mul_stage.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mul_stage
// Description : One registered partial-product step of the shift-and-add
//               multiplier. Adds (multiplicand << K) to the running sum when
//               multiplier bit K is set; the multiplier sign bit carries
//               negative weight, so the top stage subtracts instead.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_valid/o_valid - valid bit travelling with the data
//               i_a/o_a         - multiplicand (passed along)
//               i_b/o_b         - multiplier (passed along)
//               i_acc/o_acc     - partial sum in / out
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mul_stage #(
    parameter int WA = 16,
    parameter int WB = 16,
    parameter int K  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [WA-1:0]    i_a,
    input  logic        [WB-1:0]    i_b,
    input  logic signed [WA+WB-1:0] i_acc,
    output logic                    o_valid,
    output logic signed [WA-1:0]    o_a,
    output logic        [WB-1:0]    o_b,
    output logic signed [WA+WB-1:0] o_acc
);

    localparam int  c_P     = WA + WB;
    localparam bit  c_IS_MSB = (K == WB - 1);

    logic signed [c_P-1:0] w_a_ext;
    logic signed [c_P-1:0] w_addend;
    logic signed [c_P-1:0] w_acc_next;

    // The exact product fits in WA+WB bits, so any wrap of intermediate
    // partial sums cancels out by the final stage.
    assign w_a_ext  = {{WB{i_a[WA-1]}}, i_a};
    assign w_addend = w_a_ext <<< K;

    always_comb begin
        w_acc_next = i_acc;
        if (i_b[K]) begin
            if (c_IS_MSB) begin
                w_acc_next = i_acc - w_addend;
            end else begin
                w_acc_next = i_acc + w_addend;
            end
        end
    end

    logic                 r_valid;
    logic signed [WA-1:0] r_a;
    logic        [WB-1:0] r_b;
    logic signed [c_P-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
        end
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= w_acc_next;
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/pipe_fixed_point_mul.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fixed_point_mul
// Description : Fully pipelined signed fixed-point multiplier.
//               WIIB+WIFB shift-and-add stages build the exact product, then
//               a final registered stage aligns the fraction (round-half-up
//               or floor), flags overflow and either wraps or clamps.
//               Latency is WIIB+WIFB+1 cycles, one operand pair per cycle.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_valid         - operand pair valid
//               multiplicand    - WIIA.WIFA signed
//               multiplier      - WIIB.WIFB signed
//               o_valid         - out/overflow valid
//               out             - WOI.WOF signed product
//               overflow        - exact aligned product outside output range
// Options     : FXP_MUL_SATURATE_EN - defined: clamp out-of-range results;
//               undefined: keep the low WOI+WOF bits (wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fixed_point_mul
    import fixed_point_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic signed [WIIA+WIFA-1:0]   multiplicand,
    input  logic signed [WIIB+WIFB-1:0]   multiplier,
    output logic                          o_valid,
    output logic signed [WOI+WOF-1:0]     out,
    output logic                          overflow
);

    localparam int c_WA    = WIIA + WIFA;
    localparam int c_WB    = WIIB + WIFB;
    localparam int c_WO    = WOI + WOF;
    localparam int c_P     = c_WA + c_WB;
    localparam int c_SHIFT = WIFA + WIFB - WOF;

`ifdef FXP_MUL_SATURATE_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    // Index 0 is the module input; index k+1 is the output of stage k.
    logic [c_WB:0]          w_vld;
    logic signed [c_WA-1:0] w_a   [c_WB+1];
    logic [c_WB-1:0]        w_b   [c_WB+1];
    logic signed [c_P-1:0]  w_acc [c_WB+1];

    assign w_vld[0] = i_valid;
    assign w_a[0]   = multiplicand;
    assign w_b[0]   = multiplier;
    assign w_acc[0] = '0;

    for (genvar k = 0; k < c_WB; k++) begin : g_stage
        fxp_mul_stage #(
            .WA (c_WA),
            .WB (c_WB),
            .K  (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_vld[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_acc   (w_acc[k]),
            .o_valid (w_vld[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_acc   (w_acc[k+1])
        );
    end

    // Operands leaving the last stage are no longer needed.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_a[c_WB], w_b[c_WB]};

    fxp_acc_t w_prod_ext;
    fxp_acc_t w_aligned;
    fxp_acc_t w_result;
    logic     w_ovf;

    assign w_prod_ext = {{(c_FXP_ACC_W-c_P){w_acc[c_WB][c_P-1]}}, w_acc[c_WB]};
    assign w_aligned  = fxp_align(w_prod_ext, c_SHIFT, ROUND != 0);
    assign w_ovf      = fxp_out_of_range(w_aligned, c_WO);
    assign w_result   = fxp_saturate(w_aligned, c_WO, c_SAT_EN);

    logic                  r_valid;
    logic signed [c_WO-1:0] r_out;
    logic                  r_ovf;

    // Result registers only update on a valid beat so the last result is
    // held while the pipe is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_vld[c_WB];
            if (w_vld[c_WB]) begin
                r_out <= w_result[c_WO-1:0];
                r_ovf <= w_ovf;
            end
        end
    end

    assign o_valid  = r_valid;
    assign out      = r_out;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fixed_point_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_fixed_point_mul
// Description : Self-checking bench for pipe_fixed_point_mul (default Q8.8).
//               Two instances share stimulus: one rounding, one truncating.
//               Expected results are queued at drive time with the cycle on
//               which they must emerge, and compared as the outputs appear.
//               Honours FXP_MUL_SATURATE_EN for the out-of-range expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fixed_point_mul;

    localparam int c_LAT = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [15:0] mcand = 16'h0000;
    logic [15:0] mplier = 16'h0000;

    logic        o_valid_r1, o_valid_r0;
    logic [15:0] out_r1, out_r0;
    logic        ovf_r1, ovf_r0;

    always #5 clk = ~clk;

    pipe_fixed_point_mul #(.ROUND(1)) u_dut_r1 (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .o_valid      (o_valid_r1),
        .out          (out_r1),
        .overflow     (ovf_r1)
    );

    pipe_fixed_point_mul #(.ROUND(0)) u_dut_r0 (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .o_valid      (o_valid_r0),
        .out          (out_r0),
        .overflow     (ovf_r0)
    );

    typedef struct {
        logic [15:0] e1;
        logic [15:0] e0;
        logic        v1;
        logic        v0;
        int          due;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    bit          rst_q = 1'b1;
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] hold1 = 16'h0000;
    logic [15:0] hold0 = 16'h0000;
    logic        hov1 = 1'b0;
    logic        hov0 = 1'b0;

`ifdef FXP_MUL_SATURATE_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Real-number reference: exact product, scaled to 8 output fraction bits.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input bit rnd,
                         output logic [15:0] o, output logic ov);
        real    ar, br, sc;
        longint v;
        ar = real'($signed(a)) / 256.0;
        br = real'($signed(b)) / 256.0;
        sc = ar * br * 256.0;
        sc = rnd ? $floor(sc + 0.5) : $floor(sc);
        v  = longint'(sc);
        ov = (v > 32767) || (v < -32768);
        if (c_SAT && v > 32767)       o = 16'h7FFF;
        else if (c_SAT && v < -32768) o = 16'h8000;
        else                          o = v[15:0];
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q = rst;
    end

    // Output monitor: every cycle either a queued result is due, or the
    // outputs must hold (or be cleared while in reset).
    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_o_valid", {30'd0, o_valid_r1, o_valid_r0}, 32'd0);
            check("rst_out", {out_r1, out_r0}, 32'd0);
            check("rst_overflow", {30'd0, ovf_r1, ovf_r0}, 32'd0);
            hold1 = 16'h0000; hold0 = 16'h0000; hov1 = 1'b0; hov0 = 1'b0;
        end else begin
            logic exp_v;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("o_valid_r1", {31'd0, o_valid_r1}, {31'd0, exp_v});
            check("o_valid_r0", {31'd0, o_valid_r0}, {31'd0, exp_v});
            if (exp_v) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_out_r1"}, {16'd0, out_r1}, {16'd0, e.e1});
                check({e.tag, "_out_r0"}, {16'd0, out_r0}, {16'd0, e.e0});
                check({e.tag, "_ovf_r1"}, {31'd0, ovf_r1}, {31'd0, e.v1});
                check({e.tag, "_ovf_r0"}, {31'd0, ovf_r0}, {31'd0, e.v0});
                hold1 = e.e1; hold0 = e.e0; hov1 = e.v1; hov0 = e.v0;
            end else begin
                check("hold_out", {out_r1, out_r0}, {hold1, hold0});
                check("hold_ovf", {30'd0, ovf_r1, ovf_r0}, {30'd0, hov1, hov0});
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check({sb[0].tag, "_missing"}, 32'd1, 32'd0);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e1, input logic [15:0] e0,
                         input logic v1, input logic v0, input string tag);
        exp_t e;
        mcand   = a;
        mplier  = b;
        i_valid = 1'b1;
        e.e1 = e1; e.e0 = e0; e.v1 = v1; e.v0 = v0;
        e.due = cyc + c_LAT;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive_rand(input string tag);
        logic [15:0] a, b, o1, o0;
        logic        v1, v0;
        a = 16'($urandom);
        b = 16'($urandom);
        model(a, b, 1'b1, o1, v1);
        model(a, b, 1'b0, o0, v0);
        drive(a, b, o1, o0, v1, v0, tag);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_state_out", {out_r1, out_r0}, 32'd0);

        // First pair lands on the first edge after reset release.
        rst = 1'b0;
        drive(16'h0180, 16'h0200, 16'h0300, 16'h0300, 1'b0, 1'b0, "mul_1p5x2");
        drive(16'hFE80, 16'h0200, 16'hFD00, 16'hFD00, 1'b0, 1'b0, "mul_m1p5x2");
        drive(16'h0001, 16'h0080, 16'h0001, 16'h0000, 1'b0, 1'b0, "round_pos_half");
        drive(16'hFFFF, 16'h0080, 16'h0000, 16'hFFFF, 1'b0, 1'b0, "round_neg_half");
        idle(2);
        drive(16'h6400, 16'h0200, c_SAT ? 16'h7FFF : 16'hC800,
              c_SAT ? 16'h7FFF : 16'hC800, 1'b1, 1'b1, "ovf_100x2");
        drive(16'h8000, 16'h8000, c_SAT ? 16'h7FFF : 16'h0000,
              c_SAT ? 16'h7FFF : 16'h0000, 1'b1, 1'b1, "ovf_min_x_min");
        drive(16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b0, "zero_a");
        drive(16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, "zero_b");
        idle(c_LAT + 4);

        for (int i = 0; i < 20; i++) drive_rand("stream");
        idle(c_LAT + 4);

        // Reset in the middle of a stream: in-flight pairs must vanish.
        for (int i = 0; i < 5; i++) drive_rand("pre_rst");
        rst = 1'b1;
        i_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(16'h0180, 16'h0200, 16'h0300, 16'h0300, 1'b0, 1'b0, "post_rst_first");
        for (int i = 0; i < 3; i++) drive_rand("post_rst");
        idle(c_LAT + 4);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_fixed_point_mul.md
PIPE_FIXED_POINT_MUL -- requirements
Module: pipe_fixed_point_mul

Interface
REQ-001 The module SHALL have parameter WIIA, default 8, meaning multiplicand integer bits (incl. sign).
REQ-002 The module SHALL have parameter WIFA, default 8, meaning multiplicand fraction bits.
REQ-003 The module SHALL have parameter WIIB, default 8, meaning multiplier integer bits (incl. sign).
REQ-004 The module SHALL have parameter WIFB, default 8, meaning multiplier fraction bits.
REQ-005 The module SHALL have parameter WOI, default 8, meaning output integer bits (incl. sign).
REQ-006 The module SHALL have parameter WOF, default 8, meaning output fraction bits.
REQ-007 The module SHALL have parameter ROUND, default 1, meaning 1 = round-half-up and 0 = truncate (floor).
REQ-008 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-010 The module SHALL have port i_valid, input, 1 bit, marking that the operands are valid this cycle.
REQ-011 The module SHALL have port multiplicand, input, WIIA+WIFA bits, signed two's complement.
REQ-012 The module SHALL have port multiplier, input, WIIB+WIFB bits, signed two's complement.
REQ-013 The module SHALL have port o_valid, output, 1 bit, marking that out and overflow are valid.
REQ-014 The module SHALL have port out, output, WOI+WOF bits, signed two's complement product.
REQ-015 The module SHALL have port overflow, output, 1 bit, set when the exact product is outside the output range.

Function
REQ-016 The module SHALL be fully pipelined: it accepts one operand pair per cycle, has no backpressure, and never drops or reorders operands.
REQ-017 The latency SHALL be L = WIIB+WIFB+1 cycles: operands sampled at edge n SHALL appear at out/o_valid after edge n+L.
REQ-018 Pipeline stage k (0..WIIB+WIFB-1) SHALL add multiplicand<<k to the partial sum when multiplier bit k is 1; for the MSB (k = WIIB+WIFB-1) it SHALL subtract instead, giving an exact signed product with WIFA+WIFB fraction bits.
REQ-019 Final stage, fraction alignment with s = WIFA+WIFB-WOF: for s>0 with ROUND=1, the stage SHALL add 2^(s-1) and then arithmetic-shift right by s; for s>0 with ROUND=0, it SHALL arithmetic-shift right by s; for s<=0, it SHALL shift left by -s exactly.
REQ-020 overflow SHALL be 1 when the aligned value is outside [-2^(WOI+WOF-1), 2^(WOI+WOF-1)-1].
REQ-021 Out-of-range results SHALL follow REQ-034/REQ-035.
REQ-022 The valid bit SHALL travel with its data through every stage.
REQ-023 While o_valid=0, out and overflow SHALL hold their previous values.
REQ-024 A zero operand SHALL give out=0 and overflow=0.
REQ-025 Most-negative × most-negative SHALL give overflow=1.

Reset
REQ-026 While rst=1 at a clock edge, all stage valid bits, o_valid, out and overflow SHALL be cleared to 0.
REQ-027 Asserting rst mid-operation SHALL discard all in-flight operands; none of them SHALL ever appear at the output.
REQ-028 Operands with i_valid=1 sampled in the first cycle after rst deasserts SHALL emerge after exactly L cycles.

Configuration
REQ-029 Macro FXP_MUL_SATURATE_EN SHALL select the out-of-range behaviour per REQ-034/REQ-035.
REQ-030 overflow SHALL be reported identically whether or not FXP_MUL_SATURATE_EN is defined.

Structure
REQ-031 Package fixed_point_pkg SHALL hold the shared round/align/saturate function.
REQ-032 Package fixed_point_pkg SHALL hold the output-range min/max constant derivation, shared with pipe_FixedPointDiv.
REQ-033 One partial-product stage SHALL be sub-module fxp_mul_stage, instantiated WIIB+WIFB times via generate.
REQ-034 With FXP_MUL_SATURATE_EN defined, an out-of-range result SHALL clamp to max (positive) or min (negative).
REQ-035 Without FXP_MUL_SATURATE_EN, an out-of-range result SHALL wrap: out takes the low WOI+WOF bits of the aligned value.

Verification (defaults, L=17)
REQ-036 The bench SHALL check: 0x0180 × 0x0200 (1.5×2.0) -> out 0x0300, overflow 0, o_valid exactly 17 cycles after input.
REQ-037 The bench SHALL check: 0xFE80 × 0x0200 -> 0xFD00.
REQ-038 The bench SHALL check: 0x0001 × 0x0080 -> ROUND=1 gives 0x0001 and ROUND=0 gives 0x0000.
REQ-039 The bench SHALL check: 0xFFFF × 0x0080 -> ROUND=1 gives 0x0000 and ROUND=0 gives 0xFFFF.
REQ-040 The bench SHALL check: 0x6400 × 0x0200 (100×2) -> overflow 1, out 0x7FFF with the macro and 0xC800 without.
REQ-041 The bench SHALL check: 0x8000 × 0x8000 -> overflow 1, out 0x7FFF with the macro.
REQ-042 The bench SHALL check: 20 back-to-back valid random pairs -> 20 consecutive o_valid cycles, in order, matching a real-number model.
REQ-043 The bench SHALL check: rst pulsed 5 cycles after streaming starts -> no o_valid from the pre-reset operands.
REQ-044 The bench SHALL check: after the REQ-043 reset, a new pair presented at the first post-reset edge appears exactly 17 cycles later.
